// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use hazard detection.
// Bubbles (flush or invalid capture) clear every registered field, ALU source selects included.
module id_ex_stage #(
  parameter int DATAWIDTH = 32,
  parameter int REGADDR   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic [DATAWIDTH-1:0] RD1_i,
  input  logic [DATAWIDTH-1:0] RD2_i,
  input  logic [DATAWIDTH-1:0] ImmExt_i,
  input  logic [DATAWIDTH-1:0] PC_i,
  input  logic [REGADDR-1:0]   Rs1_i,
  input  logic [REGADDR-1:0]   Rs2_i,
  input  logic [REGADDR-1:0]   Rd_i,
  input  logic [3:0]           ALUctrl_i,
  input  logic                 ALUSrcA_i,
  input  logic                 ALUSrcB_i,
  input  logic                 RegWrite_i,
  input  logic                 MemRead_i,
  input  logic [REGADDR-1:0]   MemRd_i,
  input  logic [REGADDR-1:0]   WbRd_i,
  input  logic                 MemRegWrite_i,
  input  logic                 WbRegWrite_i,
  input  logic [DATAWIDTH-1:0] MemData_i,
  input  logic [DATAWIDTH-1:0] WbData_i,
  output logic [DATAWIDTH-1:0] SrcA_o,
  output logic [DATAWIDTH-1:0] SrcB_o,
  output logic [3:0]           ALUctrl_o,
  output logic [DATAWIDTH-1:0] WriteData_o,
  output logic [DATAWIDTH-1:0] PC_o,
  output logic [REGADDR-1:0]   Rd_o,
  output logic                 RegWrite_o,
  output logic                 MemRead_o,
  output logic                 valid_o,
  output logic                 hazard_o
);

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic                 mem_read;
    logic                 alu_src_a;
    logic                 alu_src_b;
    logic [3:0]           alu_ctrl;
    logic [REGADDR-1:0]   rs1;
    logic [REGADDR-1:0]   rs2;
    logic [REGADDR-1:0]   rd;
    logic [DATAWIDTH-1:0] rd1;
    logic [DATAWIDTH-1:0] rd2;
    logic [DATAWIDTH-1:0] imm;
    logic [DATAWIDTH-1:0] pc;
  } stage_t;

  stage_t stage_q;
  logic [DATAWIDTH-1:0] fwd_rs1;
  logic [DATAWIDTH-1:0] fwd_rs2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (flush_i || (!stall_i && !valid_i)) begin
      stage_q <= '0;
    end else if (!stall_i) begin
      stage_q.valid     <= 1'b1;
      stage_q.reg_write <= RegWrite_i;
      stage_q.mem_read  <= MemRead_i;
      stage_q.alu_src_a <= ALUSrcA_i;
      stage_q.alu_src_b <= ALUSrcB_i;
      stage_q.alu_ctrl  <= ALUctrl_i;
      stage_q.rs1       <= Rs1_i;
      stage_q.rs2       <= Rs2_i;
      stage_q.rd        <= Rd_i;
      stage_q.rd1       <= RD1_i;
      stage_q.rd2       <= RD2_i;
      stage_q.imm       <= ImmExt_i;
      stage_q.pc        <= PC_i;
    end
  end

  // MEM is the younger producer, so it is checked before WB; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = stage_q.rd1;
    if (MemRegWrite_i && (MemRd_i != '0) && (MemRd_i == stage_q.rs1))
      fwd_rs1 = MemData_i;
    else if (WbRegWrite_i && (WbRd_i != '0) && (WbRd_i == stage_q.rs1))
      fwd_rs1 = WbData_i;

    fwd_rs2 = stage_q.rd2;
    if (MemRegWrite_i && (MemRd_i != '0) && (MemRd_i == stage_q.rs2))
      fwd_rs2 = MemData_i;
    else if (WbRegWrite_i && (WbRd_i != '0) && (WbRd_i == stage_q.rs2))
      fwd_rs2 = WbData_i;
  end

  assign SrcA_o      = stage_q.alu_src_a ? stage_q.pc  : fwd_rs1;
  assign SrcB_o      = stage_q.alu_src_b ? stage_q.imm : fwd_rs2;
  assign WriteData_o = fwd_rs2;
  assign ALUctrl_o   = stage_q.alu_ctrl;
  assign PC_o        = stage_q.pc;
  assign Rd_o        = stage_q.rd;
  assign RegWrite_o  = stage_q.reg_write;
  assign MemRead_o   = stage_q.mem_read;
  assign valid_o     = stage_q.valid;

  assign hazard_o = stage_q.valid && stage_q.mem_read && (stage_q.rd != '0) && valid_i &&
                    ((stage_q.rd == Rs1_i) || (stage_q.rd == Rs2_i));

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset sequences, randomized run against a model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid, stall, flush;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        asa, asb, rw, mr;
    logic [4:0]  memrd, wbrd;
    logic        memrw, wbrw;
    logic [31:0] memdata, wbdata;
  } in_t;

  typedef struct packed {
    logic [31:0] srca, srcb, wd, pc;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw, mr, v, hz;
  } exp_t;

  typedef struct packed {
    in_t  in;
    exp_t e;
  } tv_t;

  logic clk = 1'b0;
  logic rst;
  logic valid_i, stall_i, flush_i;
  logic [31:0] RD1_i, RD2_i, ImmExt_i, PC_i, MemData_i, WbData_i;
  logic [4:0]  Rs1_i, Rs2_i, Rd_i, MemRd_i, WbRd_i;
  logic [3:0]  ALUctrl_i;
  logic ALUSrcA_i, ALUSrcB_i, RegWrite_i, MemRead_i, MemRegWrite_i, WbRegWrite_i;
  logic [31:0] SrcA_o, SrcB_o, WriteData_o, PC_o;
  logic [3:0]  ALUctrl_o;
  logic [4:0]  Rd_o;
  logic RegWrite_o, MemRead_o, valid_o, hazard_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATAWIDTH(32), .REGADDR(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .RD1_i(RD1_i), .RD2_i(RD2_i), .ImmExt_i(ImmExt_i), .PC_i(PC_i),
    .Rs1_i(Rs1_i), .Rs2_i(Rs2_i), .Rd_i(Rd_i), .ALUctrl_i(ALUctrl_i),
    .ALUSrcA_i(ALUSrcA_i), .ALUSrcB_i(ALUSrcB_i), .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i),
    .MemRd_i(MemRd_i), .WbRd_i(WbRd_i), .MemRegWrite_i(MemRegWrite_i), .WbRegWrite_i(WbRegWrite_i),
    .MemData_i(MemData_i), .WbData_i(WbData_i),
    .SrcA_o(SrcA_o), .SrcB_o(SrcB_o), .ALUctrl_o(ALUctrl_o), .WriteData_o(WriteData_o),
    .PC_o(PC_o), .Rd_o(Rd_o), .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o),
    .valid_o(valid_o), .hazard_o(hazard_o)
  );

  task automatic apply(input in_t x);
    valid_i = x.valid; stall_i = x.stall; flush_i = x.flush;
    RD1_i = x.rd1; RD2_i = x.rd2; ImmExt_i = x.imm; PC_i = x.pc;
    Rs1_i = x.rs1; Rs2_i = x.rs2; Rd_i = x.rd; ALUctrl_i = x.alu;
    ALUSrcA_i = x.asa; ALUSrcB_i = x.asb; RegWrite_i = x.rw; MemRead_i = x.mr;
    MemRd_i = x.memrd; WbRd_i = x.wbrd; MemRegWrite_i = x.memrw; WbRegWrite_i = x.wbrw;
    MemData_i = x.memdata; WbData_i = x.wbdata;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, want);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".SrcA"}, SrcA_o, e.srca);
    chk({tag, ".SrcB"}, SrcB_o, e.srcb);
    chk({tag, ".WriteData"}, WriteData_o, e.wd);
    chk({tag, ".PC"}, PC_o, e.pc);
    chk({tag, ".ALUctrl"}, {28'd0, ALUctrl_o}, {28'd0, e.alu});
    chk({tag, ".Rd"}, {27'd0, Rd_o}, {27'd0, e.rd});
    chk({tag, ".RegWrite"}, {31'd0, RegWrite_o}, {31'd0, e.rw});
    chk({tag, ".MemRead"}, {31'd0, MemRead_o}, {31'd0, e.mr});
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, e.v});
    chk({tag, ".hazard"}, {31'd0, hazard_o}, {31'd0, e.hz});
  endtask

  // Reference: the stage holds the last accepted instruction (or nothing); outputs follow the
  // forwarding / operand selection rules applied to whatever the MEM/WB ports show right now.
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] own, input in_t c);
    if (idx != 0 && c.memrw && c.memrd == idx) return c.memdata;
    if (idx != 0 && c.wbrw && c.wbrd == idx) return c.wbdata;
    return own;
  endfunction

  function automatic exp_t predict(input logic held, input in_t s, input in_t c);
    exp_t e;
    e = '0;
    if (held) begin
      e.srca = s.asa ? s.pc : fwd(s.rs1, s.rd1, c);
      e.srcb = s.asb ? s.imm : fwd(s.rs2, s.rd2, c);
      e.wd   = fwd(s.rs2, s.rd2, c);
      e.pc = s.pc; e.alu = s.alu; e.rd = s.rd; e.rw = s.rw; e.mr = s.mr; e.v = 1'b1;
      e.hz = s.mr && s.rd != 0 && c.valid && (s.rd == c.rs1 || s.rd == c.rs2);
    end
    return e;
  endfunction

  tv_t tbl[10];
  tv_t t;
  in_t cur, st;
  logic held;

  initial begin
    // pass-through with immediate operand
    t = '0; t.in.valid = 1; t.in.rd1 = 32'd5; t.in.imm = 32'd12; t.in.asb = 1; t.in.rs1 = 1; t.in.rs2 = 2;
    t.in.rd2 = 32'h77; t.in.pc = 32'h1000; t.in.rd = 1; t.in.rw = 1;
    t.e.srca = 5; t.e.srcb = 12; t.e.wd = 32'h77; t.e.pc = 32'h1000; t.e.rd = 1; t.e.rw = 1; t.e.v = 1;
    tbl[0] = t;
    // MEM and WB both match rs1: MEM wins
    t = '0; t.in.valid = 1; t.in.rs1 = 3; t.in.rd1 = 32'h11; t.in.rs2 = 4; t.in.rd2 = 32'h22;
    t.in.pc = 32'h1004; t.in.alu = 4'hA; t.in.rd = 5; t.in.rw = 1;
    t.in.memrd = 3; t.in.memdata = 32'hAAAA_0000; t.in.memrw = 1;
    t.in.wbrd = 3; t.in.wbdata = 32'h5555_0000; t.in.wbrw = 1;
    t.e.srca = 32'hAAAA_0000; t.e.srcb = 32'h22; t.e.wd = 32'h22; t.e.pc = 32'h1004; t.e.alu = 4'hA;
    t.e.rd = 5; t.e.rw = 1; t.e.v = 1;
    tbl[1] = t;
    // stalled, MEM write dropped: WB value now forwarded, junk inputs ignored
    t.in.stall = 1; t.in.memrw = 0; t.in.rd1 = 32'hDEAD; t.in.pc = 32'h2000; t.in.alu = 4'h1;
    t.e.srca = 32'h5555_0000;
    tbl[2] = t;
    // x0 guard on rs2
    t = '0; t.in.valid = 1; t.in.rd1 = 32'd9; t.in.memrw = 1; t.in.memdata = 32'hFFFF_FFFF;
    t.in.pc = 32'h1008; t.in.alu = 4'h3; t.in.rd = 6; t.in.rw = 1;
    t.e.srca = 9; t.e.pc = 32'h1008; t.e.alu = 4'h3; t.e.rd = 6; t.e.rw = 1; t.e.v = 1;
    tbl[3] = t;
    // valid_i=0 loads a bubble
    t = '0; t.in.rd1 = 32'h33; t.in.rs1 = 1; t.in.rs2 = 2; t.in.rd2 = 32'h44; t.in.pc = 32'h100C;
    t.in.alu = 4'h5; t.in.rd = 7; t.in.rw = 1; t.in.mr = 1; t.in.imm = 32'h55; t.in.asa = 1;
    tbl[4] = t;
    // load into x7
    t = '0; t.in.valid = 1; t.in.mr = 1; t.in.rw = 1; t.in.rd = 7; t.in.rs1 = 1; t.in.rs2 = 2;
    t.in.rd1 = 32'h100; t.in.rd2 = 32'h200; t.in.pc = 32'h1010; t.in.imm = 32'h8; t.in.asb = 1;
    t.e.srca = 32'h100; t.e.srcb = 32'h8; t.e.wd = 32'h200; t.e.pc = 32'h1010; t.e.rd = 7;
    t.e.rw = 1; t.e.mr = 1; t.e.v = 1;
    tbl[5] = t;
    // stalled, consumer reads x7 through rs2: hazard
    t.in.stall = 1; t.in.rs2 = 7; t.in.rd1 = 32'hBAD; t.in.pc = 32'h3000; t.in.rd = 9; t.in.mr = 0;
    t.e.hz = 1;
    tbl[6] = t;
    // stalled, consumer reads x9/x8: no hazard
    t.in.rs1 = 9; t.in.rs2 = 8; t.in.rd2 = 32'hCAFE; t.e.hz = 0;
    tbl[7] = t;
    // stall and flush together: flush wins
    t = '0; t.in.valid = 1; t.in.stall = 1; t.in.flush = 1; t.in.rs1 = 7; t.in.rd = 3; t.in.rw = 1;
    t.in.rd1 = 32'h99; t.in.pc = 32'h4000;
    tbl[8] = t;
    // load into x0 never raises a hazard
    t = '0; t.in.valid = 1; t.in.mr = 1; t.in.rw = 1; t.in.rd1 = 32'd3; t.in.pc = 32'h1014;
    t.e.srca = 3; t.e.pc = 32'h1014; t.e.rw = 1; t.e.mr = 1; t.e.v = 1;
    tbl[9] = t;

    rst = 1'b1;
    apply('0);
    #2;
    check_all("reset", '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      apply(tbl[i].in);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].e);
    end

    // asynchronous reset between edges
    @(negedge clk);
    apply(tbl[5].in);
    @(posedge clk);
    #1;
    chk("pre_rst.valid", {31'd0, valid_o}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", '0);
    // reset held across an edge with stall and flush asserted, then first capture after release
    t = '0; t.in.valid = 1; t.in.stall = 1; t.in.flush = 1;
    apply(t.in);
    @(posedge clk);
    #1;
    check_all("rst_over_stall", '0);
    @(negedge clk);
    rst = 1'b0;
    apply(tbl[0].in);
    @(posedge clk);
    #1;
    check_all("post_rst", tbl[0].e);

    // randomized run against the reference
    held = 1'b1;
    st = tbl[0].in;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      cur = '0;
      cur.valid = ($urandom_range(0, 9) < 8);
      cur.stall = ($urandom_range(0, 3) == 0);
      cur.flush = ($urandom_range(0, 9) == 0);
      cur.rd1 = $urandom; cur.rd2 = $urandom; cur.imm = $urandom; cur.pc = $urandom;
      cur.rs1 = 5'($urandom_range(0, 3)); cur.rs2 = 5'($urandom_range(0, 3));
      cur.rd = 5'($urandom_range(0, 3)); cur.alu = 4'($urandom);
      cur.asa = 1'($urandom); cur.asb = 1'($urandom); cur.rw = 1'($urandom); cur.mr = 1'($urandom);
      cur.memrd = 5'($urandom_range(0, 3)); cur.wbrd = 5'($urandom_range(0, 3));
      cur.memrw = 1'($urandom); cur.wbrw = 1'($urandom);
      cur.memdata = $urandom; cur.wbdata = $urandom;
      apply(cur);
      if (cur.flush || (!cur.stall && !cur.valid)) begin
        held = 1'b0;
        st = '0;
      end else if (!cur.stall) begin
        held = 1'b1;
        st = cur;
      end
      @(posedge clk);
      #1;
      check_all($sformatf("rnd%0d", n), predict(held, st, cur));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
